// File: rtl/adder_check_pkg.sv
// Shared types and helpers for the adder result checker.
//   DefWidth / DefCntW : default operand width and counter width
//   txn_t              : one default-width transaction {a, b, sum}
//   sat_inc            : saturating increment for counters up to CntMaxW bits
package adder_check_pkg;

  localparam int unsigned DefWidth = 4;
  localparam int unsigned DefCntW  = 16;
  localparam int unsigned CntMaxW  = 32;

  typedef struct packed {
    logic [DefWidth-1:0] a;
    logic [DefWidth-1:0] b;
    logic [DefWidth:0]   sum;
  } txn_t;

  // The count is passed zero-extended to CntMaxW bits. cnt_w is the real counter width.
  // The result stops at all-ones of that width.
  function automatic logic [CntMaxW-1:0] sat_inc(input logic [CntMaxW-1:0] count,
                                                 input int unsigned       cnt_w);
    logic [CntMaxW-1:0] max_val;
    if (cnt_w >= CntMaxW) begin
      max_val = '1;
    end else begin
      max_val = (CntMaxW'(1) << cnt_w) - CntMaxW'(1);
    end
    if (count >= max_val) begin
      sat_inc = max_val;
    end else begin
      sat_inc = count + CntMaxW'(1);
    end
  endfunction

endpackage

// File: rtl/adder_result_checker_if.sv
// Bundle of the checker's transaction input and verdict output.
//   valid/ready/a/b/sum        : transaction input (valid/ready handshake)
//   result_valid/result_ready  : verdict handshake
//   pass                       : verdict of the presented transaction
//   pass_count/fail_count/error: running statistics
// Optional (CHECKER_FIRST_FAIL_CAPTURE_EN): fail_a/fail_b/fail_sum hold the first failing
// transaction that was accepted downstream.
// Modports: slave = checker side, master = producer/consumer side.
interface adder_result_checker_if
  import adder_check_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CNT_W = DefCntW
);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   sum;

  logic             result_valid;
  logic             result_ready;
  logic             pass;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] fail_count;
  logic             error;

`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
  logic [WIDTH-1:0] fail_a;
  logic [WIDTH-1:0] fail_b;
  logic [WIDTH:0]   fail_sum;
`endif

  modport slave (
    input  valid, a, b, sum, result_ready,
`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
    output fail_a, fail_b, fail_sum,
`endif
    output ready, result_valid, pass, pass_count, fail_count, error
  );

  modport master (
    output valid, a, b, sum, result_ready,
`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
    input  fail_a, fail_b, fail_sum,
`endif
    input  ready, result_valid, pass, pass_count, fail_count, error
  );

endinterface

// File: rtl/adder_check_stage.sv
// Generic one-entry valid/ready pipeline register.
//   clk_i, reset_i       : clock, synchronous active-high reset
//   in_valid/in_ready    : upstream handshake, in_data payload
//   out_valid/out_ready  : downstream handshake, out_data payload
// The stage accepts new data whenever it is empty or its content leaves in the same cycle.
// Holding and draining in the same cycle therefore causes no bubble.
module adder_check_stage #(
  parameter type data_t = logic
) (
  input  logic  clk_i,
  input  logic  reset_i,
  input  logic  in_valid,
  output logic  in_ready,
  input  data_t in_data,
  output logic  out_valid,
  input  logic  out_ready,
  output data_t out_data
);

  logic  valid_q;
  data_t data_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) begin
        data_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/adder_result_checker.sv
// Consumer-side checker for an adder.
// A transaction {a, b, sum} arrives and the checker recomputes a + b at WIDTH+1 bits.
// The checker then presents a pass/fail verdict two cycles after the transaction is accepted.
//   clk_i, reset_i : clock, synchronous active-high reset (drops all in-flight data)
//   bus (slave)    : transaction input, verdict output, statistics
// Stage S1 registers the transaction. Stage S2 registers the compare result.
// pass_count/fail_count saturate and count only verdicts accepted downstream.
// error is sticky until reset.
// Optional feature macro: CHECKER_FIRST_FAIL_CAPTURE_EN adds fail_a/fail_b/fail_sum.
// Those outputs hold the first failing accepted verdict.
module adder_result_checker
  import adder_check_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CNT_W = DefCntW
) (
  input logic                  clk_i,
  input logic                  reset_i,
  adder_result_checker_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;
  } txn_w_t;

  typedef struct packed {
    txn_w_t txn;
    logic   pass;
  } verdict_t;

  // S1: raw transaction
  txn_w_t s1_in;
  txn_w_t s1_data;
  logic   s1_valid;
  logic   s1_ready;

  // S2: transaction plus verdict
  verdict_t s2_in;
  verdict_t s2_data;
  logic     s2_valid;
  logic     s2_ready;

  logic [WIDTH:0] expected;
  logic           verdict_acc;

  assign s1_in.a   = bus.a;
  assign s1_in.b   = bus.b;
  assign s1_in.sum = bus.sum;

  adder_check_stage #(
    .data_t (txn_w_t)
  ) u_s1 (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .in_valid  (bus.valid),
    .in_ready  (s1_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_data)
  );

  // The carry out is part of the compare, so a truncated sum fails.
  assign expected   = {1'b0, s1_data.a} + {1'b0, s1_data.b};
  assign s2_in.txn  = s1_data;
  assign s2_in.pass = (s1_data.sum == expected);

  adder_check_stage #(
    .data_t (verdict_t)
  ) u_s2 (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (s2_valid),
    .out_ready (bus.result_ready),
    .out_data  (s2_data)
  );

  assign bus.ready        = s1_ready;
  assign bus.result_valid = s2_valid;
  assign bus.pass         = s2_data.pass;

  assign verdict_acc = s2_valid && bus.result_ready;

  // Statistics
  logic [CNT_W-1:0] pass_count_q, pass_count_d;
  logic [CNT_W-1:0] fail_count_q, fail_count_d;
  logic             error_q, error_d;

  always_comb begin
    pass_count_d = pass_count_q;
    fail_count_d = fail_count_q;
    error_d      = error_q;
    if (verdict_acc) begin
      if (s2_data.pass) begin
        pass_count_d = CNT_W'(sat_inc(CntMaxW'(pass_count_q), CNT_W));
      end else begin
        fail_count_d = CNT_W'(sat_inc(CntMaxW'(fail_count_q), CNT_W));
        error_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pass_count_q <= '0;
      fail_count_q <= '0;
      error_q      <= 1'b0;
    end else begin
      pass_count_q <= pass_count_d;
      fail_count_q <= fail_count_d;
      error_q      <= error_d;
    end
  end

  assign bus.pass_count = pass_count_q;
  assign bus.fail_count = fail_count_q;
  assign bus.error      = error_q;

`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
  // Capture on the same edge that raises error. A clear error_q marks the first failure.
  logic             capture_en;
  logic [WIDTH-1:0] fail_a_q, fail_a_d;
  logic [WIDTH-1:0] fail_b_q, fail_b_d;
  logic [WIDTH:0]   fail_sum_q, fail_sum_d;

  assign capture_en = verdict_acc && !s2_data.pass && !error_q;

  always_comb begin
    fail_a_d   = fail_a_q;
    fail_b_d   = fail_b_q;
    fail_sum_d = fail_sum_q;
    if (capture_en) begin
      fail_a_d   = s2_data.txn.a;
      fail_b_d   = s2_data.txn.b;
      fail_sum_d = s2_data.txn.sum;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      fail_sum_q <= '0;
    end else begin
      fail_a_q   <= fail_a_d;
      fail_b_q   <= fail_b_d;
      fail_sum_q <= fail_sum_d;
    end
  end

  assign bus.fail_a   = fail_a_q;
  assign bus.fail_b   = fail_b_q;
  assign bus.fail_sum = fail_sum_q;
`endif

endmodule
